// File: rtl/arbitro_rr_serial.sv
// Round-robin byte scheduler ahead of the parallel-to-serial converter.
// Trains the link with COM symbols, then grants one requester byte per clk_4f cycle.
module arbitro_rr_serial #(
  parameter int          NUM_REQ      = 4,
  parameter int          DATA_W       = 8,
  parameter logic [DATA_W-1:0] COM    = 8'hBC,
  parameter int          TRAIN_CYCLES = 4
) (
  input  logic                        clk_4f,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        rx_active,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_pop,
  output logic [DATA_W-1:0]           data2send,
  output logic                        valid2send,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [1:0]                  state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRAIN = 2'b01,
    RUN   = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CW-1:0]     r_trainCnt;
  logic [CW-1:0]     w_trainCntNext;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    w_winner;
  logic              w_found;
  logic              w_grant;
  logic [DATA_W-1:0] w_winData;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [IDW-1:0]    r_gid;

  // Saturating count of COM symbols sent in the current training pass
  assign w_trainCntNext = (r_trainCnt == CW'(TRAIN_CYCLES)) ? r_trainCnt : r_trainCnt + CW'(1);

  // Search order starts at the pointer; iterating downwards lets the nearest requester win
  always_comb begin
    logic [IDW-1:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = r_ptr + IDW'(k);
      if (req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin
    w_winData = COM;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == w_winner) w_winData = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Exit conditions are folded in so no pop happens in a cycle that leaves RUN
  assign w_grant = !reset && (r_state == RUN) && enable && rx_active && w_found;

  always_ff @(posedge clk_4f) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (enable) w_stateNext = TRAIN;
      TRAIN: begin
        if (!enable)                                                 w_stateNext = IDLE;
        else if (w_trainCntNext == CW'(TRAIN_CYCLES) && rx_active)   w_stateNext = RUN;
      end
      RUN: begin
        if (!enable)         w_stateNext = IDLE;
        else if (!rx_active) w_stateNext = TRAIN;
      end
      default:               w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    req_pop = '0;
    if (w_grant) req_pop[w_winner] = 1'b1;
  end

  // Outside TRAIN the counter sits at zero, so every entry into TRAIN starts a fresh pass
  always_ff @(posedge clk_4f) begin
    if (reset || r_state != TRAIN) r_trainCnt <= '0;
    else                           r_trainCnt <= w_trainCntNext;
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_data  <= COM;
      r_valid <= 1'b0;
      r_gid   <= '0;
      r_ptr   <= '0;
    end else if (w_grant) begin
      r_data  <= w_winData;
      r_valid <= 1'b1;
      r_gid   <= w_winner;
      r_ptr   <= w_winner + IDW'(1);
    end else begin
      r_data  <= COM;
      r_valid <= 1'b0;
    end
  end

  assign data2send  = r_data;
  assign valid2send = r_valid;
  assign grant_id   = r_gid;
  assign state      = r_state;

endmodule

// File: tb/tb_arbitro_rr_serial.sv
// Self-checking bench for arbitro_rr_serial: directed link scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_arbitro_rr_serial;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TC  = 4;
  localparam logic [7:0] COMSYM = 8'hBC;

  logic            clk_4f;
  logic            reset;
  logic            enable;
  logic            rx_active;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_pop;
  logic [DW-1:0]   data2send;
  logic            valid2send;
  logic [1:0]      grant_id;
  logic [1:0]      state;

  int vectors;
  int miscompares;

  // Reference model: link phase as text-like integers, plus the expected registered outputs
  int          mPhase;    // 0 idle, 1 training, 2 running
  int          mComsSent;
  int          mNext;
  int          mData;
  int          mValid;
  int          mGid;

  arbitro_rr_serial #(
    .NUM_REQ(N), .DATA_W(DW), .COM(COMSYM), .TRAIN_CYCLES(TC)
  ) dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable), .rx_active(rx_active),
    .req_valid(req_valid), .req_data(req_data), .req_pop(req_pop),
    .data2send(data2send), .valid2send(valid2send), .grant_id(grant_id),
    .state(state)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Requester that would be served now, or -1 when nobody is served
  function automatic int modelWinner();
    if (reset || mPhase != 2 || !enable || !rx_active) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(mNext + k) % N]) return (mNext + k) % N;
    end
    return -1;
  endfunction

  task automatic modelAdvance(input int winner);
    mData  = COMSYM;
    mValid = 0;
    if (reset) begin
      mPhase = 0; mComsSent = 0; mNext = 0; mGid = 0;
      return;
    end
    case (mPhase)
      0: if (enable) begin mPhase = 1; mComsSent = 0; end
      1: begin
        if (!enable) mPhase = 0;
        else begin
          if (mComsSent < TC) mComsSent++;
          if (mComsSent == TC && rx_active) mPhase = 2;
        end
      end
      default: begin
        if (!enable) mPhase = 0;
        else if (!rx_active) begin mPhase = 1; mComsSent = 0; end
        else if (winner >= 0) begin
          mData  = req_data[winner*DW +: DW];
          mValid = 1;
          mGid   = winner;
          mNext  = (winner + 1) % N;
        end
      end
    endcase
  endtask

  // One clk_4f cycle: drive, check the combinational pop, clock, check registered outputs
  task automatic applyStimulus(input logic rst, input logic en, input logic rx,
                               input logic [N-1:0] vld, input logic [N*DW-1:0] dat);
    int w;
    logic [N-1:0] expPop;
    reset = rst; enable = en; rx_active = rx; req_valid = vld; req_data = dat;
    #2;
    w = modelWinner();
    expPop = '0;
    if (w >= 0) expPop[w] = 1'b1;
    checkOutput("req_pop", 32'(req_pop), 32'(expPop));
    @(posedge clk_4f);
    modelAdvance(w);
    #1;
    checkOutput("state", 32'(state), 32'(mPhase));
    checkOutput("data2send", 32'(data2send), 32'(mData));
    checkOutput("valid2send", 32'(valid2send), 32'(mValid));
    checkOutput("grant_id", 32'(grant_id), 32'(mGid));
  endtask

  initial begin
    int trainSeen;
    logic [N*DW-1:0] allData;
    vectors = 0; miscompares = 0;
    mPhase = 0; mComsSent = 0; mNext = 0; mData = COMSYM; mValid = 0; mGid = 0;
    reset = 1'b1; enable = 1'b0; rx_active = 1'b0; req_valid = '0; req_data = '0;
    allData = {8'h40, 8'h30, 8'h20, 8'h10};
    @(posedge clk_4f); #1;

    $display("[TB] reset and training with far end already active");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, allData);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, allData);
    trainSeen = 0;
    for (int i = 0; i < 12 && state != 2'b10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, allData);
      if (state == 2'b01) trainSeen++;
    end
    checkOutput("train_len", 32'(trainSeen), 32'(TC));

    $display("[TB] training held by inactive far end");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, allData);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, allData);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, allData);
    checkOutput("run_after_rx", 32'(state), 32'h2);

    $display("[TB] all requesters valid");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'hF, allData);

    $display("[TB] single requester then idle");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00});
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, allData);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1001, {8'h77, 8'h00, 8'h00, 8'h66});
    checkOutput("ptr_after_lane2", 32'(grant_id), 32'h3);

    $display("[TB] far end drops for one cycle");
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00});
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00});

    $display("[TB] reset in the middle of traffic");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, allData);
    checkOutput("gid_after_reset", 32'(grant_id), 32'h0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 15) != 0),
                    ($urandom_range(0, 9) != 0),
                    N'($urandom),
                    {$urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
